// File: rtl/aes_result_scroller.sv
// aes_result_scroller
//
// Display sequencer for the AES result bus. One 128-bit result is captured
// over a valid/ready handshake and compared against the known-answer vector.
// Its 16 bytes are then stepped, most significant first, onto byte_out. Each
// byte is held for TICK_DIV clock cycles. hold freezes the stepping.
//
// Optional feature macro: SCROLL_LOOP_EN
//   undefined (default): a single pass ends in DONE, which holds byte 15.
//   defined: the scroll wraps from byte 15 back to byte 0 forever. done
//            pulses for one cycle on each wrap. A new result may be captured
//            at any time; a capture restarts the scroll at byte 0.
//
// Reset is asynchronous and active-low on port `reset`.

module aes_result_scroller #(
  parameter int TICK_DIV = 50000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         result_valid,
  output logic         result_ready,
  input  logic [127:0] result_data,
  input  logic [127:0] expected_data,
  input  logic         hold,
  output logic [7:0]   byte_out,
  output logic [3:0]   byte_idx,
  output logic         match,
  output logic         busy,
  output logic         done
);

  // Tick counter sizing. TICK_DIV=1 still needs a 1-bit counter, which then
  // sits permanently at its terminal count of 0.
  localparam int            TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [3:0]    LAST_BYTE = 4'd15;

  // State encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Registered state
  logic [1:0]        state_q,    state_d;
  logic [127:0]      data_q,     data_d;
  logic              match_q,    match_d;
  logic [3:0]        idx_q,      idx_d;
  logic [TICK_W-1:0] tick_q,     tick_d;
  logic [7:0]        byte_out_q, byte_out_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;

  logic              capture;
  logic              wrap;

  // Pick byte idx of a 128-bit word, byte 0 being bits [127:120].
  function automatic logic [7:0] sel_byte(input logic [127:0] d,
                                          input logic [3:0]   idx);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (idx == 4'(i)) r = d[127-8*i -: 8];
    end
    return r;
  endfunction

  // result_ready is decoded straight from state. state_q is IDLE during
  // reset, so ready reads 1 while reset is held.
`ifdef SCROLL_LOOP_EN
  assign result_ready = 1'b1;
`else
  assign result_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
`endif

  assign capture = result_valid && result_ready;

  // Next-state logic: capture first, then tick and byte stepping in SHOW.
  always_comb begin
    // NOTE: every signal gets a default here, so no path through the block
    // can leave a value unassigned and infer a latch.
    state_d = state_q;
    data_d  = data_q;
    match_d = match_q;
    idx_d   = idx_q;
    tick_d  = tick_q;
    wrap    = 1'b0;

    if (capture) begin
      // A capture beats the tick step on the same edge. This only matters
      // in loop mode, where capture is allowed during SHOW.
      state_d = ST_SHOW;
      data_d  = result_data;
      match_d = (result_data == expected_data);
      idx_d   = '0;
      tick_d  = '0;
    end else if ((state_q == ST_SHOW) && !hold) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        if (idx_q == LAST_BYTE) begin
`ifdef SCROLL_LOOP_EN
          idx_d = '0;
          wrap  = 1'b1;
`else
          // byte_idx stays at 15, so byte_out keeps showing byte 15.
          state_d = ST_DONE;
`endif
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end

    // All outputs are registered. They are computed from next-state values
    // so that they line up with state on the same edge.
    busy_d     = (state_d == ST_SHOW);
    done_d     = (state_d == ST_DONE) || wrap;
    byte_out_d = (state_d == ST_IDLE) ? 8'h00 : sel_byte(data_d, idx_d);
  end

  // Control and output registers: asynchronous clear back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample their _d values from before the edge, whatever order the
    // statements appear in.
    if (!reset) begin
      state_q    <= ST_IDLE;
      match_q    <= 1'b0;
      idx_q      <= '0;
      tick_q     <= '0;
      byte_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      match_q    <= match_d;
      idx_q      <= idx_d;
      tick_q     <= tick_d;
      byte_out_q <= byte_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Captured result word. It has a load enable and no reset.
  always_ff @(posedge clk) begin
    // NOTE: the 128-bit data register has no reset. It is only read after a
    // capture has loaded it, and byte_out is forced to 0 in IDLE.
    data_q <= data_d;
  end

  assign byte_out = byte_out_q;
  assign byte_idx = idx_q;
  assign match    = match_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Structural invariants of the stepping logic.
  a_tick_in_range : assert property (@(posedge clk) disable iff (!reset)
    tick_q <= TICK_LAST);
  a_idle_quiet : assert property (@(posedge clk) disable iff (!reset)
    (state_q == ST_IDLE) |-> (idx_q == 4'd0 && !busy_q && !done_q));
  a_busy_is_show : assert property (@(posedge clk) disable iff (!reset)
    busy_q == (state_q == ST_SHOW));

endmodule

// File: tb/tb_aes_result_scroller.sv
// Testbench for aes_result_scroller (TICK_DIV=4).
//
// The reference model knows only the scroll at an abstract level:
//  - whether a result has been captured;
//  - how many un-held cycles have elapsed since that capture;
//  - the captured word and its match flag.
// Every output is derived from those with plain arithmetic.
// The stimulus process advances the model and queues the expected outputs
// for each edge. A monitor process pops the queue and compares against the
// DUT one delay step after each edge.

module tb_aes_result_scroller;

  localparam int T    = 4;
  localparam int PASS = 16 * T;
`ifdef SCROLL_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         result_valid;
  logic         result_ready;
  logic [127:0] result_data;
  logic [127:0] expected_data;
  logic         hold;
  logic [7:0]   byte_out;
  logic [3:0]   byte_idx;
  logic         match;
  logic         busy;
  logic         done;

  aes_result_scroller #(.TICK_DIV(T)) dut (
    .clk           (clk),
    .reset         (reset),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_data   (result_data),
    .expected_data (expected_data),
    .hold          (hold),
    .byte_out      (byte_out),
    .byte_idx      (byte_idx),
    .match         (match),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic [3:0] idx;
    logic       m;
    logic       busy;
    logic       done;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit           m_cap  = 1'b0;
  int           m_el   = 0;
  logic [127:0] m_data = '0;
  bit           m_match = 1'b0;
  bit           m_wrap = 1'b0;

  function automatic bit m_busy();
    return m_cap && (LOOP || m_el < PASS);
  endfunction

  function automatic bit m_ready();
    return LOOP || !m_busy();
  endfunction

  function automatic exp_t m_out();
    exp_t r;
    int   k;
    logic [127:0] sh;
    r.b = '0; r.idx = '0; r.m = 1'b0; r.busy = 1'b0; r.done = 1'b0; r.rdy = 1'b1;
    if (m_cap) begin
      k = LOOP ? (m_el / T) % 16 : ((m_el / T) > 15 ? 15 : m_el / T);
      sh = m_data >> (8 * (15 - k));
      r.b    = sh[7:0];
      r.idx  = 4'(k);
      r.m    = m_match;
      r.busy = m_busy();
      r.done = LOOP ? m_wrap : (m_el >= PASS);
      r.rdy  = m_ready();
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: drive the inputs, advance the model across the coming
  // edge, and queue what the DUT should show after it. It is entered and left
  // 2 time units after a rising edge.
  task automatic cyc(input bit v, input logic [127:0] rd, input logic [127:0] ed,
                     input bit h);
    result_valid  = v;
    result_data   = rd;
    expected_data = ed;
    hold          = h;
    if (v && m_ready()) begin
      m_cap   = 1'b1;
      m_el    = 0;
      m_data  = rd;
      m_match = (rd == ed);
      m_wrap  = 1'b0;
    end else if (m_busy() && !h) begin
      m_el++;
      m_wrap = LOOP && (m_el % PASS == 0);
    end else begin
      m_wrap = 1'b0;
    end
    q.push_back(m_out());
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, rand128(), rand128(), 1'b0);
  endtask

  // Idle until the model says byte k is on display, with a cycle budget.
  task automatic wait_idx(input int k);
    exp_t o;
    bit   found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      o = m_out();
      if (o.idx == 4'(k)) found = 1'b1;
      else idle(1);
    end
    check("wait_idx_reached", found, 1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("byte_out",     byte_out,     e.b);
        check("byte_idx",     byte_idx,     e.idx);
        check("match",        match,        e.m);
        check("busy",         busy,         e.busy);
        check("done",         done,         e.done);
        check("result_ready", result_ready, e.rdy);
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [127:0] kat;
  logic [127:0] d;

  initial begin
    reset = 1'b0; result_valid = 1'b0; result_data = '0;
    expected_data = '0; hold = 1'b0;
    #3;
    check("rst_byte_out", byte_out, 0);
    check("rst_byte_idx", byte_idx, 0);
    check("rst_match",    match,    0);
    check("rst_busy",     busy,     0);
    check("rst_done",     done,     0);
    check("rst_ready",    result_ready, 1);
    #20 reset = 1'b1;
    @(posedge clk);
    #2;

    // Known-answer pass: match=1, full sequence, then DONE holding 0x5a.
    kat = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    cyc(1'b1, kat, kat, 1'b0);
    idle(70);

    // Mismatch (last byte differs). hold for 10 cycles during byte 3. A
    // valid with different data at byte 7 must be ignored.
    cyc(1'b1, 128'h00112233445566778899aabbccddeeff,
              128'h00112233445566778899aabbccddeefe, 1'b0);
    wait_idx(3);
    for (int i = 0; i < 10; i++) cyc(1'b0, rand128(), rand128(), 1'b1);
    wait_idx(7);
    cyc(1'b1, rand128(), rand128(), 1'b0);
    idle(80);

    // Async reset pulse, shorter than a clock period, in the middle of byte 9.
    d = rand128();
    cyc(1'b1, d, d, 1'b0);
    wait_idx(9);
    idle(1);
    reset = 1'b0;
    #1;
    check("arst_byte_out", byte_out, 0);
    check("arst_byte_idx", byte_idx, 0);
    check("arst_match",    match,    0);
    check("arst_busy",     busy,     0);
    check("arst_done",     done,     0);
    check("arst_ready",    result_ready, 1);
    #1 reset = 1'b1;
    m_cap = 1'b0; m_el = 0; m_match = 1'b0; m_wrap = 1'b0;
    d = rand128();
    cyc(1'b1, d, rand128(), 1'b0);
    idle(70);

    // Randomized traffic: sparse valids, random hold, matching or random
    // expected data.
    for (int i = 0; i < 800; i++) begin
      d = rand128();
      cyc($urandom_range(0, 7) == 0, d,
          ($urandom_range(0, 1) == 0) ? d : rand128(),
          $urandom_range(0, 5) == 0);
    end
    idle(70);

    @(posedge clk);
    #3;
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_result_scroller.md
# aes_result_scroller

Downstream display sequencer for the AES cipher/decipher result bus. Captures one 128-bit result with a valid/ready handshake and compares it against the known-answer vector. Then steps the 16 result bytes, most significant first, onto an 8-bit output at a programmable rate. The 8-bit output feeds the existing binary-to-BCD and 7-segment chain, so the whole block can be read on three digits.

## Interface
Parameters:
- TICK_DIV, default 50000000 — clock cycles each byte is shown; legal range ≥1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- result_valid  in  1  result_data is valid this cycle.
- result_ready  out  1  block can accept a capture; high in IDLE and DONE.
- result_data  in  128  cipher or decipher output; byte 0 = bits [127:120].
- expected_data  in  128  known-answer vector; sampled together with result_data.
- hold  in  1  freezes the byte-step counter while high.
- byte_out  out  8  byte currently displayed.
- byte_idx  out  4  index of byte_out, 0..15.
- match  out  1  captured result equalled expected_data at capture.
- busy  out  1  high while stepping through bytes.
- done  out  1  high in DONE state; pulses one cycle per wrap when SCROLL_LOOP_EN is defined.

## Operation
- States:
  - IDLE: waiting for a result.
  - SHOW: stepping through bytes.
  - DONE: holding the last byte.
- Capture occurs on any edge with result_valid && result_ready. At capture:
  - data_reg ← result_data.
  - match ← (result_data == expected_data).
  - byte_idx ← 0, tick counter ← 0, state → SHOW.
- In SHOW:
  - byte_out = data_reg[127-8*byte_idx -: 8], registered.
  - The tick counter increments each cycle in which hold=0.
  - At TICK_DIV-1 the counter wraps to 0 and byte_idx increments.
- When byte_idx=15 and the counter reaches its terminal count:
  - state → DONE.
  - byte_idx stays 15 and byte_out stays byte 15.
- In DONE: busy=0, done=1, match is held, result_ready=1. A new capture restarts SHOW.
- In SHOW, result_ready=0 and result_valid is ignored (without SCROLL_LOOP_EN).
- Tick counter width is max(1, $clog2(TICK_DIV)). It never exceeds TICK_DIV-1.
- Assertion of hold:
  - hold=1 freezes the counter and byte_idx; the state does not change.
  - hold has no effect in IDLE or DONE.
  - Capture is not blocked by hold.

## Timing
- Reset values, all outputs registered: byte_out=0, byte_idx=0, match=0, busy=0, done=0, state=IDLE.
- result_ready is decoded from state and reads 1 while reset is held.
- Reset asserted mid-SHOW: the block returns to IDLE immediately and asynchronously, and all outputs are cleared.
- Capture latency: 1 cycle. The cycle after the capture edge has busy=1, byte_idx=0, byte_out=byte 0 and match valid.
- With hold=0, each byte is shown for exactly TICK_DIV cycles. SHOW lasts 16×TICK_DIV cycles.
- TICK_DIV=1: byte_idx advances every cycle.
- DONE is entered on the edge ending the final tick of byte 15.
- Simultaneous result_valid and the terminal tick in SHOW (no SCROLL_LOOP_EN): the valid is ignored. DONE is entered, and the capture happens on a later cycle.

## Configuration
- SCROLL_LOOP_EN defined:
  - After byte 15, byte_idx wraps to 0 and the block stays in SHOW indefinitely.
  - done pulses high for one cycle on each wrap.
  - result_ready=1 in SHOW as well. A capture in SHOW restarts at byte 0 with counter 0, and capture has priority over the tick step on the same edge.
  - DONE is unreachable.
- SCROLL_LOOP_EN undefined: behaviour is exactly as in Operation; a single pass ends in DONE.

## Test plan
All scenarios use TICK_DIV=4.
- Match pass:
  - Stimulus: capture result_data = expected_data = 0x69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: match=1. byte_out sequence is 0x69,0xc4,…,0x5a, each for 4 cycles. done=1 at cycle 65 after capture; byte_out then stays 0x5a.
- Mismatch:
  - Stimulus: result_data = 0x00112233445566778899aabbccddeeff, expected_data = 0x00112233445566778899aabbccddeefe.
  - Required: match=0; byte 15 reads 0xff.
- Hold:
  - Stimulus: hold=1 for 10 cycles during byte_idx=3.
  - Required: byte 3 is shown for 14 cycles; DONE arrives 10 cycles late.
- Ignore during SHOW:
  - Stimulus: pulse result_valid with different data at byte_idx=7.
  - Required: no change to the sequence; result_ready=0.
- Async reset:
  - Stimulus: reset low mid-byte 9, for less than one clock period.
  - Required: outputs are 0 immediately; result_ready=1; the next capture starts at byte 0.
- Loop (SCROLL_LOOP_EN defined):
  - Stimulus: run one full pass, then capture new data at byte_idx=5 of the second pass.
  - Required: after byte 15, byte_idx returns to 0 with a one-cycle done pulse. The new capture restarts at byte 0 of the new data.
